// File: rtl/parking_keypad_entry.sv
// Parking entrance keypad: debounces key presses and captures a two-digit password for the controller.
// Optional macro KEYPAD_ECHO_EN adds the echo_valid/echo_digit key echo outputs.
module parking_keypad_entry #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sensor_entrance,
    input  logic       key_press,
    input  logic [1:0] key_value,
    input  logic       key_clear,
    input  logic       pwd_ready,
    output logic [1:0] password_1,
    output logic [1:0] password_2,
    output logic       pwd_valid,
    output logic [1:0] digit_count,
    output logic       entry_timeout
`ifdef KEYPAD_ECHO_EN
    ,
    output logic       echo_valid,
    output logic [1:0] echo_digit
`endif
);

    typedef enum logic [2:0] {IDLE, WAIT_D1, WAIT_D2, PRESENT, TIMEOUT} state_t;

    localparam logic [7:0]  DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]  DEB_FULL = 8'(DEBOUNCE_CYCLES);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nx;
    logic [7:0]  deb_cnt, deb_nx;
    logic [15:0] tmo_cnt, tmo_nx;
    logic [1:0]  pwd1_nx, pwd2_nx, count_nx;
    logic        key_hit, key_take;

    // Debounce runs in every state and saturates past the accept point, so one press yields one key.
    assign key_hit = key_press && (deb_cnt == DEB_LAST);

    always_comb begin
        deb_nx = deb_cnt;
        if (!key_press)
            deb_nx = '0;
        else if (deb_cnt != DEB_FULL)
            deb_nx = deb_cnt + 8'd1;
    end

    always_comb begin
        state_nx = state;
        pwd1_nx  = password_1;
        pwd2_nx  = password_2;
        count_nx = digit_count;
        tmo_nx   = tmo_cnt;
        key_take = 1'b0;
        case (state)
            IDLE: begin
                tmo_nx = '0;
                if (sensor_entrance)
                    state_nx = WAIT_D1;
            end
            WAIT_D1, WAIT_D2: begin
                tmo_nx = tmo_cnt + 16'd1;
                // Priority: car leaves, clear key, accepted key, timeout.
                if (!sensor_entrance || key_clear) begin
                    state_nx = sensor_entrance ? WAIT_D1 : IDLE;
                    pwd1_nx  = '0;
                    pwd2_nx  = '0;
                    count_nx = '0;
                    tmo_nx   = '0;
                end else if (key_hit) begin
                    key_take = 1'b1;
                    tmo_nx   = '0;
                    if (state == WAIT_D1) begin
                        pwd1_nx  = key_value;
                        count_nx = 2'd1;
                        state_nx = WAIT_D2;
                    end else begin
                        pwd2_nx  = key_value;
                        count_nx = 2'd2;
                        state_nx = PRESENT;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_nx   = '0;
                    state_nx = TIMEOUT;
                end
            end
            PRESENT: begin
                if (pwd_ready) begin
                    state_nx = IDLE;
                    pwd1_nx  = '0;
                    pwd2_nx  = '0;
                    count_nx = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                pwd1_nx  = '0;
                pwd2_nx  = '0;
                count_nx = '0;
                tmo_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            password_1  <= '0;
            password_2  <= '0;
            digit_count <= '0;
            deb_cnt     <= '0;
            tmo_cnt     <= '0;
        end else begin
            password_1  <= pwd1_nx;
            password_2  <= pwd2_nx;
            digit_count <= count_nx;
            deb_cnt     <= deb_nx;
            tmo_cnt     <= tmo_nx;
        end
    end

    assign pwd_valid     = (state == PRESENT);
    assign entry_timeout = (state == TIMEOUT);

`ifdef KEYPAD_ECHO_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            echo_valid <= 1'b0;
            echo_digit <= '0;
        end else begin
            echo_valid <= key_take;
            if (key_take)
                echo_digit <= key_value;
        end
    end
`else
    logic unused_take;
    assign unused_take = key_take;
`endif

endmodule

// File: tb/tb_parking_keypad_entry.sv
// Bench for parking_keypad_entry: directed scenarios plus random stimulus against a digit-queue model.
module tb_parking_keypad_entry;

    localparam int DEB = 4;
    localparam int TMO = 200;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sensor_entrance = 1'b0;
    logic       key_press = 1'b0;
    logic [1:0] key_value = 2'd0;
    logic       key_clear = 1'b0;
    logic       pwd_ready = 1'b0;
    logic [1:0] password_1, password_2, digit_count;
    logic       pwd_valid, entry_timeout;

    int total = 0;
    int bad = 0;

    // Reference model: an entry is a queue of captured digits.
    int run = 0;
    bit active = 0;
    bit tpulse = 0;
    int idle = 0;
    int q[$];

    always #5 clk = ~clk;

    parking_keypad_entry #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .sensor_entrance(sensor_entrance),
        .key_press(key_press), .key_value(key_value), .key_clear(key_clear),
        .pwd_ready(pwd_ready), .password_1(password_1), .password_2(password_2),
        .pwd_valid(pwd_valid), .digit_count(digit_count), .entry_timeout(entry_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        run = 0; active = 0; tpulse = 0; idle = 0;
        q.delete();
    endtask

    task automatic model_step();
        bit hit;
        if (!reset_n) begin
            model_reset();
            return;
        end
        run = key_press ? run + 1 : 0;
        hit = key_press && (run == DEB);
        if (tpulse) begin
            tpulse = 0; idle = 0;
            q.delete();
        end else if (!active) begin
            if (sensor_entrance) begin
                active = 1; idle = 0;
            end
        end else if (q.size() == 2) begin
            if (pwd_ready) begin
                active = 0;
                q.delete();
            end
        end else if (!sensor_entrance) begin
            active = 0;
            q.delete();
        end else if (key_clear) begin
            q.delete();
            idle = 0;
        end else if (hit) begin
            q.push_back(int'(key_value));
            idle = 0;
        end else if (idle == TMO - 1) begin
            active = 0; tpulse = 1; idle = 0;
        end else begin
            idle++;
        end
    endtask

    task automatic check_all();
        logic [1:0] e1, e2;
        e1 = (q.size() > 0) ? 2'(q[0]) : 2'd0;
        e2 = (q.size() > 1) ? 2'(q[1]) : 2'd0;
        chk("password_1", password_1, e1);
        chk("password_2", password_2, e2);
        chk("digit_count", digit_count, q.size());
        chk("pwd_valid", pwd_valid, (active && q.size() == 2) ? 1 : 0);
        chk("entry_timeout", entry_timeout, tpulse ? 1 : 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic press(input logic [1:0] v, input int n);
        key_value = v;
        key_press = 1'b1;
        repeat (n) tick();
        key_press = 1'b0;
        tick();
    endtask

    initial begin
        int pulses;
        int first_k;
        int hold;

        // Reset state
        model_reset();
        tick();
        tick();
        chk("rst_password_1", password_1, 0);
        chk("rst_pwd_valid", pwd_valid, 0);
        chk("rst_digit_count", digit_count, 0);
        reset_n = 1'b1;
        tick();
        chk("idle_no_sensor_count", digit_count, 0);

        // Normal entry with handshake
        sensor_entrance = 1'b1;
        tick();
        press(2'd1, DEB);
        chk("normal_d1_count", digit_count, 1);
        press(2'd2, DEB);
        chk("normal_password_1", password_1, 1);
        chk("normal_password_2", password_2, 2);
        chk("normal_pwd_valid", pwd_valid, 1);
        tick();
        tick();
        chk("normal_valid_held", pwd_valid, 1);
        pwd_ready = 1'b1;
        tick();
        pwd_ready = 1'b0;
        chk("handshake_valid", pwd_valid, 0);
        chk("handshake_password_1", password_1, 0);
        chk("handshake_password_2", password_2, 0);
        chk("handshake_count", digit_count, 0);

        // Bounce: 3 high, 1 low, 3 high
        sensor_entrance = 1'b0;
        tick();
        sensor_entrance = 1'b1;
        tick();
        press(2'd3, DEB - 1);
        press(2'd3, DEB - 1);
        chk("bounce_count", digit_count, 0);

        // pwd_ready ignored outside PRESENT
        pwd_ready = 1'b1;
        tick();
        pwd_ready = 1'b0;
        chk("ready_ignored_count", digit_count, 0);

        // Long hold then timeout
        press(2'd3, 50);
        chk("long_hold_count", digit_count, 1);
        chk("long_hold_password_1", password_1, 3);
        sensor_entrance = 1'b0;
        tick();
        sensor_entrance = 1'b1;
        tick();
        press(2'd1, DEB);
        pulses = 0;
        first_k = -1;
        for (int k = 1; k <= 260; k++) begin
            tick();
            if (entry_timeout === 1'b1) begin
                pulses++;
                if (first_k < 0) first_k = k;
            end
            if (k == 200) begin
                chk("after_timeout_password_1", password_1, 0);
                chk("after_timeout_count", digit_count, 0);
            end
        end
        chk("timeout_pulses", pulses, 1);
        chk("timeout_cycle", first_k, TMO - 1);

        // Clear on the accepting edge in WAIT_D2
        sensor_entrance = 1'b0;
        tick();
        sensor_entrance = 1'b1;
        tick();
        press(2'd1, DEB);
        key_value = 2'd2;
        key_press = 1'b1;
        repeat (DEB - 1) tick();
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        chk("clear_accept_count", digit_count, 0);
        chk("clear_accept_password_1", password_1, 0);
        repeat (3) tick();
        key_press = 1'b0;
        tick();
        press(2'd3, DEB);
        chk("after_clear_count", digit_count, 1);
        chk("after_clear_valid", pwd_valid, 0);

        // Sensor drop keeps PRESENT, then async reset
        press(2'd0, DEB);
        chk("present_valid", pwd_valid, 1);
        sensor_entrance = 1'b0;
        tick();
        chk("present_sensor_drop", pwd_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_valid", pwd_valid, 0);
        chk("async_rst_password_1", password_1, 0);
        chk("async_rst_password_2", password_2, 0);
        chk("async_rst_count", digit_count, 0);
        tick();
        reset_n = 1'b1;
        tick();
        sensor_entrance = 1'b1;
        tick();

        // Key held across IDLE -> WAIT_D1 is consumed once
        sensor_entrance = 1'b0;
        tick();
        key_value = 2'd1;
        key_press = 1'b1;
        repeat (DEB + 1) tick();
        sensor_entrance = 1'b1;
        repeat (10) tick();
        chk("held_across_count", digit_count, 0);
        key_press = 1'b0;
        tick();

        // Sensor drop aborts an entry in WAIT_D2
        press(2'd2, DEB);
        sensor_entrance = 1'b0;
        tick();
        chk("abort_count", digit_count, 0);
        chk("abort_password_1", password_1, 0);

        // Random stimulus against the model
        hold = 1;
        for (int c = 0; c < 3000; c++) begin
            hold--;
            if (hold <= 0) begin
                key_press = ~key_press;
                if (key_press) begin
                    hold = $urandom_range(1, 7);
                    key_value = 2'($urandom_range(0, 3));
                end else begin
                    hold = ($urandom_range(0, 99) == 0) ? 205 : $urandom_range(1, 4);
                end
            end
            sensor_entrance = ($urandom_range(0, 24) != 0);
            key_clear = ($urandom_range(0, 39) == 0);
            pwd_ready = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
